// File: rtl/cpu_types_pkg.sv
// -----------------------------------------------------------------------------
// cpu_types_pkg
// Shared types for the MIPS pipeline. Holds the register-number type, the
// tracked-producer record used by the forwarding/hazard unit, and the forward
// select value that means "read from the register file".
// -----------------------------------------------------------------------------
package cpu_types_pkg;

   localparam int REG_W = 5;

   typedef logic [REG_W-1:0] regbits_t;

   // One in-flight register writer as seen by the forwarding unit.
   typedef struct packed {
      logic     valid;
      regbits_t rd;
      logic     load;
   } fwd_entry_t;

   // Forward select value meaning "no forwarding, use register file data".
   localparam int FWD_RF = 0;

endpackage

// File: rtl/fwd_hazard_unit_if.sv
// -----------------------------------------------------------------------------
// fwd_hazard_unit_if
// Bundles the issue-side inputs and forwarding/stall outputs of
// fwd_hazard_unit. The fhu modport is the unit's own view.
// -----------------------------------------------------------------------------
interface fwd_hazard_unit_if
   import cpu_types_pkg::*;
#(
   parameter int NSTAGES = 3,
   parameter int NSRC    = 2,
   parameter int CNTW    = 32
) ();

   localparam int FSELW = $clog2(NSTAGES + 1);

   logic                        issue_valid;
   logic                        issue_wen;
   regbits_t                    issue_rd;
   logic                        issue_load;
   regbits_t [NSRC-1:0]         src_reg;
   logic     [NSRC-1:0]         src_used;
   logic                        hold;
   logic                        flush;
   logic [NSRC-1:0][FSELW-1:0]  fwd_sel;
   logic                        stall;
   logic [CNTW-1:0]             stall_cnt;

   modport fhu (
      input  issue_valid, issue_wen, issue_rd, issue_load,
      input  src_reg, src_used, hold, flush,
      output fwd_sel, stall, stall_cnt
   );

endinterface

// File: rtl/fwd_match.sv
// -----------------------------------------------------------------------------
// fwd_match
// Combinational priority search of one source operand over the tracked
// producer entries. Reports whether any entry matches, the index of the
// youngest (lowest-index) match, and whether that entry's data is ready.
//   entries_i  : tracked producers, entry 0 youngest
//   src_reg_i  : source register number
//   src_used_i : operand is actually read
//   hit_o      : some entry matches
//   idx_o      : index of youngest matching entry
//   ready_o    : youngest match can be forwarded now
// -----------------------------------------------------------------------------
module fwd_match
   import cpu_types_pkg::*;
#(
   parameter  int NSTAGES    = 3,
   parameter  int LOAD_READY = 1,
   localparam int IDXW       = (NSTAGES > 1) ? $clog2(NSTAGES) : 1
) (
   input  fwd_entry_t [NSTAGES-1:0] entries_i,
   input  regbits_t                 src_reg_i,
   input  logic                     src_used_i,
   output logic                     hit_o,
   output logic [IDXW-1:0]          idx_o,
   output logic                     ready_o
);

   // Walk from oldest to youngest so the last match written is the youngest.
   always_comb begin
      // NOTE: every output gets a default before the loop; a path that leaves
      // one unassigned would infer a latch.
      hit_o   = 1'b0;
      idx_o   = '0;
      ready_o = 1'b0;
      for (int k = NSTAGES - 1; k >= 0; k--) begin
         if (src_used_i && entries_i[k].valid &&
             entries_i[k].rd == src_reg_i && entries_i[k].rd != '0) begin
            hit_o   = 1'b1;
            idx_o   = IDXW'(k);
            ready_o = !entries_i[k].load || (k >= LOAD_READY);
         end
      end
   end

endmodule

// File: rtl/fwd_hazard_unit.sv
// -----------------------------------------------------------------------------
// fwd_hazard_unit
// Forwarding and load-use hazard unit. Keeps a shift register of the last
// NSTAGES register writers that entered EX and, for each source operand of
// the instruction in decode, selects a forwarding entry or requests a stall
// when the youngest matching producer is a load whose data is not yet out.
//   CLK, RST          : clock, asynchronous active-high reset
//   issue_*           : instruction in decode trying to enter EX
//   src_reg, src_used : its source registers and which ones are read
//   hold              : global freeze, all state holds
//   flush             : branch flush, the issuing instruction is dropped
//   fwd_sel           : per-source select, 0 = register file, k = entry k-1
//   stall             : hold decode, bubble into EX
//   stall_cnt         : saturating count of stalled, non-held cycles
// -----------------------------------------------------------------------------
module fwd_hazard_unit
   import cpu_types_pkg::*;
#(
   parameter  int NSTAGES    = 3,
   parameter  int NSRC       = 2,
   parameter  int LOAD_READY = 1,
   parameter  int CNTW       = 32,
   localparam int FSELW      = $clog2(NSTAGES + 1)
) (
   input  logic                       CLK,
   input  logic                       RST,
   input  logic                       issue_valid,
   input  logic                       issue_wen,
   input  regbits_t                   issue_rd,
   input  logic                       issue_load,
   input  regbits_t [NSRC-1:0]        src_reg,
   input  logic     [NSRC-1:0]        src_used,
   input  logic                       hold,
   input  logic                       flush,
   output logic [NSRC-1:0][FSELW-1:0] fwd_sel,
   output logic                       stall,
   output logic [CNTW-1:0]            stall_cnt
);

   localparam int IDXW = (NSTAGES > 1) ? $clog2(NSTAGES) : 1;

   fwd_entry_t [NSTAGES-1:0] entries_q, entries_d;
   logic [CNTW-1:0]          stall_cnt_q, stall_cnt_d;

   logic [NSRC-1:0]            hit, ready, need_stall;
   logic [NSRC-1:0][IDXW-1:0]  idx;

   for (genvar s = 0; s < NSRC; s++) begin : g_src
      fwd_match #(
         .NSTAGES    (NSTAGES),
         .LOAD_READY (LOAD_READY)
      ) u_match (
         .entries_i  (entries_q),
         .src_reg_i  (src_reg[s]),
         .src_used_i (src_used[s]),
         .hit_o      (hit[s]),
         .idx_o      (idx[s]),
         .ready_o    (ready[s])
      );

      // A not-ready youngest match forces the register file path; an older
      // ready match would carry stale data and is deliberately ignored.
      assign fwd_sel[s]    = (hit[s] && ready[s]) ? FSELW'(idx[s]) + FSELW'(1)
                                                  : FSELW'(FWD_RF);
      assign need_stall[s] = hit[s] && !ready[s];
   end

   // Flush wins over stall: the consumer is being discarded anyway.
   assign stall     = issue_valid && !flush && |need_stall;
   assign stall_cnt = stall_cnt_q;

   always_comb begin
      entries_d   = entries_q;
      stall_cnt_d = stall_cnt_q;
      if (!hold) begin
         for (int k = NSTAGES - 1; k > 0; k--) begin
            entries_d[k] = entries_q[k-1];
         end
         entries_d[0].valid = issue_valid && issue_wen && !stall && !flush;
         entries_d[0].rd    = issue_rd;
         entries_d[0].load  = issue_load;
         if (stall && stall_cnt_q != '1) begin
            stall_cnt_d = stall_cnt_q + CNTW'(1);
         end
      end
   end

   // NOTE: state registers use non-blocking assignments so every flop samples
   // its pre-edge value; the entries are flops, not RAM, and are all reset so
   // the valid bits are defined from the first cycle.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         entries_q   <= '0;
         stall_cnt_q <= '0;
      end else begin
         entries_q   <= entries_d;
         stall_cnt_q <= stall_cnt_d;
      end
   end

endmodule

// File: tb/tb_fwd_hazard_unit.sv
// -----------------------------------------------------------------------------
// tb_fwd_hazard_unit
// Directed vectors for fwd_hazard_unit with hand-computed expectations. The
// driver applies one vector per cycle and queues its expected outputs; a
// monitor pops and compares on the following falling edge.
// -----------------------------------------------------------------------------
module tb_fwd_hazard_unit;
   import cpu_types_pkg::*;

   localparam int NSTAGES = 3;
   localparam int NSRC    = 2;
   localparam int CNTW    = 32;
   localparam int FSELW   = 2;

   logic                       CLK = 1'b0;
   logic                       RST = 1'b1;
   logic                       issue_valid = 1'b0;
   logic                       issue_wen   = 1'b0;
   regbits_t                   issue_rd    = '0;
   logic                       issue_load  = 1'b0;
   regbits_t [NSRC-1:0]        src_reg     = '0;
   logic     [NSRC-1:0]        src_used    = '0;
   logic                       hold  = 1'b0;
   logic                       flush = 1'b0;
   logic [NSRC-1:0][FSELW-1:0] fwd_sel;
   logic                       stall;
   logic [CNTW-1:0]            stall_cnt;

   always #5 CLK = ~CLK;

   fwd_hazard_unit #(
      .NSTAGES    (NSTAGES),
      .NSRC       (NSRC),
      .LOAD_READY (1),
      .CNTW       (CNTW)
   ) dut (
      .CLK         (CLK),
      .RST         (RST),
      .issue_valid (issue_valid),
      .issue_wen   (issue_wen),
      .issue_rd    (issue_rd),
      .issue_load  (issue_load),
      .src_reg     (src_reg),
      .src_used    (src_used),
      .hold        (hold),
      .flush       (flush),
      .fwd_sel     (fwd_sel),
      .stall       (stall),
      .stall_cnt   (stall_cnt)
   );

   typedef struct {
      string           name;
      logic [FSELW-1:0] f0;
      logic [FSELW-1:0] f1;
      logic            st;
      logic [CNTW-1:0] cnt;
   } exp_t;

   exp_t exp_q[$];
   int   checks = 0;
   int   errors = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   // Monitor: one expectation per cycle, compared mid-cycle.
   always @(negedge CLK) begin : monitor
      exp_t e;
      if (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         check({e.name, ".fwd_sel0"}, 32'(fwd_sel[0]), 32'(e.f0));
         check({e.name, ".fwd_sel1"}, 32'(fwd_sel[1]), 32'(e.f1));
         check({e.name, ".stall"},    32'(stall),      32'(e.st));
         check({e.name, ".stall_cnt"}, stall_cnt,      e.cnt);
      end
   end

   // Driver: apply one vector after the rising edge and queue its expectation.
   // With rs=1 the inputs settle first, then reset is asserted mid-cycle.
   task automatic step(input string name,
                       input logic v, input logic wen, input int rd, input logic ld,
                       input int s0, input logic u0, input int s1, input logic u1,
                       input logic hl, input logic fl, input logic rs,
                       input int ef0, input int ef1, input logic est, input int ecnt);
      exp_t e;
      @(posedge CLK);
      #1;
      issue_valid = v;
      issue_wen   = wen;
      issue_rd    = regbits_t'(rd);
      issue_load  = ld;
      src_reg[0]  = regbits_t'(s0);
      src_reg[1]  = regbits_t'(s1);
      src_used    = {u1, u0};
      hold        = hl;
      flush       = fl;
      if (rs) begin
         #1;
         RST = 1'b1;
      end else begin
         RST = 1'b0;
      end
      e.name = name;
      e.f0   = FSELW'(ef0);
      e.f1   = FSELW'(ef1);
      e.st   = est;
      e.cnt  = CNTW'(ecnt);
      exp_q.push_back(e);
   endtask

   initial begin
      //    name           v  wen rd ld  s0 u0 s1 u1  hl fl rs  f0 f1 st cnt
      step("in_reset",     0, 0,  0, 0,  0, 0, 0, 0,  0, 0, 1,  0, 0, 0, 0);
      step("idle",         0, 0,  0, 0,  0, 0, 0, 0,  0, 0, 0,  0, 0, 0, 0);
      // ALU back-to-back, then the same producer seen from entries 1 and 2
      step("add3",         1, 1,  3, 0,  0, 0, 0, 0,  0, 0, 0,  0, 0, 0, 0);
      step("use3_e0",      1, 0,  0, 0,  3, 1, 0, 0,  0, 0, 0,  1, 0, 0, 0);
      step("use3_e1",      1, 0,  0, 0,  0, 0, 3, 1,  0, 0, 0,  0, 2, 0, 0);
      step("use3_e2",      1, 0,  0, 0,  3, 1, 0, 0,  0, 0, 0,  3, 0, 0, 0);
      // load-use: one stall, then forward from entry 1
      step("lw5",          1, 1,  5, 1,  0, 0, 0, 0,  0, 0, 0,  0, 0, 0, 0);
      step("use5_stall",   1, 1,  6, 0,  0, 0, 5, 1,  0, 0, 0,  0, 0, 1, 0);
      step("use5_fwd",     1, 1,  6, 0,  0, 0, 5, 1,  0, 0, 0,  0, 2, 0, 1);
      // priority, two-source independence, register 0
      step("wr7_a",        1, 1,  7, 0,  0, 0, 0, 0,  0, 0, 0,  0, 0, 0, 1);
      step("wr7_b",        1, 1,  7, 0,  0, 0, 0, 0,  0, 0, 0,  0, 0, 0, 1);
      step("use7_6",       1, 1,  0, 1,  7, 1, 6, 1,  0, 0, 0,  1, 3, 0, 1);
      step("use0_7",       1, 0,  0, 0,  0, 1, 7, 1,  0, 0, 0,  0, 2, 0, 1);
      step("use7_e2",      1, 0,  0, 0,  7, 1, 0, 0,  0, 0, 0,  3, 0, 0, 1);
      // youngest of entry 0 and entry 2 wins
      step("wr9_a",        1, 1,  9, 0,  0, 0, 0, 0,  0, 0, 0,  0, 0, 0, 1);
      step("nop",          0, 0,  0, 0,  0, 0, 0, 0,  0, 0, 0,  0, 0, 0, 1);
      step("wr9_b",        1, 1,  9, 0,  0, 0, 0, 0,  0, 0, 0,  0, 0, 0, 1);
      step("use9",         1, 0,  0, 0,  9, 1, 0, 0,  0, 0, 0,  1, 0, 0, 1);
      // older ready ALU result must not bypass a younger pending load
      step("add10",        1, 1, 10, 0,  0, 0, 0, 0,  0, 0, 0,  0, 0, 0, 1);
      step("lw10",         1, 1, 10, 1,  0, 0, 0, 0,  0, 0, 0,  0, 0, 0, 1);
      step("use10_stall",  1, 0,  0, 0, 10, 1, 0, 0,  0, 0, 0,  0, 0, 1, 1);
      step("use10_fwd",    1, 0,  0, 0, 10, 1, 0, 0,  0, 0, 0,  2, 0, 0, 2);
      // hold during a load-use stall
      step("lw5_h",        1, 1,  5, 1,  0, 0, 0, 0,  0, 0, 0,  0, 0, 0, 2);
      for (int i = 0; i < 4; i++) begin
         step("use5_hold", 1, 0,  0, 0,  5, 1, 0, 0,  1, 0, 0,  0, 0, 1, 2);
      end
      step("use5_rel",     1, 0,  0, 0,  5, 1, 0, 0,  0, 0, 0,  0, 0, 1, 2);
      step("use5_after",   1, 0,  0, 0,  5, 1, 0, 0,  0, 0, 0,  2, 0, 0, 3);
      // flush beats stall; flushed writer leaves a bubble
      step("lw8",          1, 1,  8, 1,  0, 0, 0, 0,  0, 0, 0,  0, 0, 0, 3);
      step("use8_flush",   1, 1, 11, 0,  0, 0, 8, 1,  0, 1, 0,  0, 0, 0, 3);
      step("post_flush",   1, 0,  0, 0, 11, 1, 8, 1,  0, 0, 0,  0, 2, 0, 3);
      // unused operands never match
      step("lw12",         1, 1, 12, 1,  0, 0, 0, 0,  0, 0, 0,  0, 0, 0, 3);
      step("unused12",     1, 0,  0, 0, 12, 0,12, 0,  0, 0, 0,  0, 0, 0, 3);
      // reset asserted during a stall
      step("lw13",         1, 1, 13, 1,  0, 0, 0, 0,  0, 0, 0,  0, 0, 0, 3);
      step("use13_stall",  1, 0,  0, 0, 13, 1, 0, 0,  0, 0, 0,  0, 0, 1, 3);
      step("lw14",         1, 1, 14, 1,  0, 0, 0, 0,  0, 0, 0,  0, 0, 0, 4);
      step("rst_mid",      1, 0,  0, 0, 14, 1, 0, 0,  0, 0, 1,  0, 0, 0, 0);
      step("rst_release",  1, 0,  0, 0, 14, 1, 0, 0,  0, 0, 0,  0, 0, 0, 0);

      for (int i = 0; i < 10 && exp_q.size() > 0; i++) begin
         @(negedge CLK);
         #1;
      end
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL drain: got %0d pending, expected 0", exp_q.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
